// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with Avalon-MM register access.
// One shared period counter drives NUM_CH PWM/direction pairs. Host writes
// land in shadow registers and reach the active set only at a period wrap
// (or continuously while the block is disabled), so outputs never glitch.
// A direction flip blanks that channel's PWM for DEAD_CYCLES clocks.
module pwm_gen_multi #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int ADDR_W         = 4,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int DEAD_CYCLES    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_dir
);

  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [DW-1:0]     DEAD_INIT   = DW'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0]  PERIOD_INIT = CNT_W'(DEFAULT_PERIOD);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(3);

  logic              ctrl_en;
  logic              ctrl_ie;
  logic              wrap_flag;
  logic [CNT_W-1:0]  period_sh;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_act [NUM_CH];
  logic [NUM_CH-1:0] dir_sh;
  logic [NUM_CH-1:0] chen_sh;
  logic [NUM_CH-1:0] dir_act;
  logic [NUM_CH-1:0] chen_act;
  logic [DW-1:0]     dead_cnt [NUM_CH];

  logic              counting;
  logic              boundary;
  logic              load_act;
  logic              status_clr;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata[31:CNT_W];

  // Period timing: running, wrap detection and when the active set may reload.
  // A zero active period stalls the counter, so reloading then cannot glitch.
  always_comb begin
    counting   = ctrl_en && (period_act != '0);
    boundary   = counting && (cnt == period_act - CNT_W'(1));
    load_act   = !ctrl_en || boundary || (period_act == '0);
    status_clr = avs_write && (avs_address == A_STATUS) && avs_writedata[0];
  end

  // Host-visible shadow and control registers written over Avalon.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_ie   <= 1'b0;
      period_sh <= PERIOD_INIT;
      dir_sh    <= '0;
      chen_sh   <= '0;
      for (int k = 0; k < NUM_CH; k++) duty_sh[k] <= '0;
    end else if (avs_write) begin
      if (avs_address == A_CTRL) begin
        ctrl_en <= avs_writedata[0];
        ctrl_ie <= avs_writedata[1];
      end
      if (avs_address == A_PERIOD) period_sh <= avs_writedata[CNT_W-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (avs_address == ADDR_W'(4 + 2 * k)) duty_sh[k] <= avs_writedata[CNT_W-1:0];
        if (avs_address == ADDR_W'(5 + 2 * k)) begin
          dir_sh[k]  <= avs_writedata[0];
          chen_sh[k] <= avs_writedata[1];
        end
      end
    end
  end

  // Wrap flag: a wrap in the same cycle as a host clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        wrap_flag <= 1'b0;
    else if (boundary)   wrap_flag <= 1'b1;
    else if (status_clr) wrap_flag <= 1'b0;
  end

  // Shared period counter, parked at zero whenever it is not running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt <= '0;
    else if (!counting || boundary) cnt <= '0;
    else                          cnt <= cnt + CNT_W'(1);
  end

  // Active register set, refreshed from the shadows only at safe points.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_act <= PERIOD_INIT;
      dir_act    <= '0;
      chen_act   <= '0;
      for (int k = 0; k < NUM_CH; k++) duty_act[k] <= '0;
    end else if (load_act) begin
      period_act <= period_sh;
      dir_act    <= dir_sh;
      chen_act   <= chen_sh;
      for (int k = 0; k < NUM_CH; k++) duty_act[k] <= duty_sh[k];
    end
  end

  // Per-channel dead-time counters, restarted whenever an applied DIR flips.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) dead_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load_act && (dir_sh[k] != dir_act[k])) dead_cnt[k] <= DEAD_INIT;
        else if (dead_cnt[k] != '0)                dead_cnt[k] <= dead_cnt[k] - DW'(1);
      end
    end
  end

  // Registered PWM, direction and interrupt outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= '0;
      pwm_dir <= '0;
      irq     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        pwm_out[k] <= ctrl_en && chen_act[k] && (cnt < duty_act[k]) && (dead_cnt[k] == '0);
      end
      pwm_dir <= dir_act;
      irq     <= wrap_flag && ctrl_ie;
    end
  end

  // Read multiplexer over the shadow registers; unmapped words read zero.
  always_comb begin
    rd_mux = '0;
    if (avs_address == A_CTRL)   rd_mux = {30'd0, ctrl_ie, ctrl_en};
    if (avs_address == A_PERIOD) rd_mux = 32'(period_sh);
    if (avs_address == A_STATUS) rd_mux = {31'd0, wrap_flag};
    if (avs_address == A_COUNT)  rd_mux = 32'(cnt);
    for (int k = 0; k < NUM_CH; k++) begin
      if (avs_address == ADDR_W'(4 + 2 * k)) rd_mux = 32'(duty_sh[k]);
      if (avs_address == ADDR_W'(5 + 2 * k)) rd_mux = {30'd0, chen_sh[k], dir_sh[k]};
    end
  end

  // Read data register: one-cycle latency, holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Testbench for pwm_gen_multi: directed scenarios plus random register
// traffic, checked cycle by cycle against a behavioural model through a
// scoreboard queue.
module tb_pwm_gen_multi;

  localparam int NCH  = 4;
  localparam int DEAD = 4;

  logic        clk;
  logic        reset_n;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [NCH-1:0] pwm_out;
  logic [NCH-1:0] pwm_dir;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] dir;
    logic           irq;
    logic [31:0]    rd;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  bit   m_en, m_ie, m_wrap;
  int   m_period_sh, m_period_act, m_cnt;
  int   m_duty_sh[NCH], m_duty_act[NCH], m_dead[NCH];
  bit   m_dir_sh[NCH], m_chen_sh[NCH], m_dir_act[NCH], m_chen_act[NCH];
  logic [31:0] m_last_rd;

  pwm_gen_multi #(
    .NUM_CH(NCH), .CNT_W(16), .ADDR_W(4),
    .DEFAULT_PERIOD(50000), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .pwm_out(pwm_out), .pwm_dir(pwm_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_ie = 0; m_wrap = 0;
    m_period_sh = 50000; m_period_act = 50000; m_cnt = 0;
    for (int k = 0; k < NCH; k++) begin
      m_duty_sh[k] = 0; m_duty_act[k] = 0; m_dead[k] = 0;
      m_dir_sh[k] = 0; m_chen_sh[k] = 0; m_dir_act[k] = 0; m_chen_act[k] = 0;
    end
    m_last_rd = '0;
  endfunction

  function automatic logic [31:0] reg_value(input int a);
    int k;
    case (a)
      0: return {30'd0, m_ie, m_en};
      1: return 32'(m_period_sh);
      2: return {31'd0, m_wrap};
      3: return 32'(m_cnt);
      default: begin
        if (a >= 4 && a < 4 + 2 * NCH) begin
          k = (a - 4) / 2;
          if (a % 2 == 0) return 32'(m_duty_sh[k]);
          return {30'd0, m_chen_sh[k], m_dir_sh[k]};
        end
        return 32'd0;
      end
    endcase
  endfunction

  // One clock of the reference model; pushes what the DUT must show after it.
  function automatic void model_step(input int a, input bit r, input bit w, input logic [31:0] d);
    exp_t e;
    bit running, wraps, take;
    int k;
    running = m_en && (m_period_act > 0);
    wraps   = running && (m_cnt + 1 == m_period_act);
    for (int i = 0; i < NCH; i++) begin
      e.pwm[i] = m_en && m_chen_act[i] && (m_cnt < m_duty_act[i]) && (m_dead[i] == 0);
      e.dir[i] = m_dir_act[i];
    end
    e.irq = m_wrap && m_ie;
    if (r) m_last_rd = reg_value(a);
    e.rd = m_last_rd;

    take = !m_en || wraps || (m_period_act == 0);
    for (int i = 0; i < NCH; i++) begin
      if (take && (m_dir_act[i] != m_dir_sh[i])) m_dead[i] = DEAD;
      else if (m_dead[i] > 0)                    m_dead[i] = m_dead[i] - 1;
    end
    if (take) begin
      m_period_act = m_period_sh;
      for (int i = 0; i < NCH; i++) begin
        m_duty_act[i] = m_duty_sh[i];
        m_dir_act[i]  = m_dir_sh[i];
        m_chen_act[i] = m_chen_sh[i];
      end
    end
    m_cnt = wraps ? 0 : (running ? m_cnt + 1 : 0);
    if (wraps) m_wrap = 1;
    else if (w && a == 2 && d[0]) m_wrap = 0;

    if (w) begin
      if (a == 0) begin m_en = d[0]; m_ie = d[1]; end
      else if (a == 1) m_period_sh = int'(d[15:0]);
      else if (a >= 4 && a < 4 + 2 * NCH) begin
        k = (a - 4) / 2;
        if (a % 2 == 0) m_duty_sh[k] = int'(d[15:0]);
        else begin m_dir_sh[k] = d[0]; m_chen_sh[k] = d[1]; end
      end
    end
    exp_q.push_back(e);
  endfunction

  // Drive one cycle of bus activity (called at a falling edge).
  task automatic apply_stimulus(input logic [3:0] a, input logic r, input logic w, input logic [31:0] d);
    avs_address = a; avs_read = r; avs_write = w; avs_writedata = d;
    model_step(int'(a), r, w, d);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    apply_stimulus(a, 1'b0, 1'b1, d);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    apply_stimulus(a, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic count_high(input int n, input int ch, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0);
      highs += int'(pwm_out[ch]);
    end
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 60) begin
      idle(1);
      n++;
    end
    if (m_cnt != target) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_cnt actual=%0d expected=%0d (timeout)", m_cnt, target);
    end
  endtask

  // Scoreboard monitor: one expectation per clock, sampled just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("pwm_out", 32'(pwm_out), 32'(e.pwm));
      check_output("pwm_dir", 32'(pwm_dir), 32'(e.dir));
      check_output("irq", 32'(irq), 32'(e.irq));
      check_output("readdata", avs_readdata, e.rd);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int highs;
    logic [3:0] a;
    int op;
    reset_n = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_output("reset_pwm_out", 32'(pwm_out), 32'd0);
    check_output("reset_pwm_dir", 32'(pwm_dir), 32'd0);
    check_output("reset_irq", 32'(irq), 32'd0);
    check_output("reset_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;

    $display("[TB] basic PWM");
    rd_reg(4'd1);
    check_output("reset_period_read", avs_readdata, 32'd50000);
    wr_reg(4'd1, 32'd10);
    wr_reg(4'd4, 32'd3);
    wr_reg(4'd5, 32'd2);
    wr_reg(4'd0, 32'd1);
    idle(12);
    count_high(10, 0, highs);
    check_output("basic_ch0_highs", 32'(highs), 32'd3);
    count_high(10, 3, highs);
    check_output("basic_ch3_highs", 32'(highs), 32'd0);
    for (int i = 0; i < 12; i++) rd_reg(4'd3);

    $display("[TB] duty limits");
    wr_reg(4'd6, 32'd0);
    wr_reg(4'd7, 32'd2);
    idle(12);
    count_high(10, 1, highs);
    check_output("duty0_highs", 32'(highs), 32'd0);
    wr_reg(4'd6, 32'd10);
    idle(12);
    count_high(10, 1, highs);
    check_output("duty_eq_period_highs", 32'(highs), 32'd10);
    wr_reg(4'd6, 32'd15);
    idle(12);
    count_high(10, 1, highs);
    check_output("duty_gt_period_highs", 32'(highs), 32'd10);

    $display("[TB] shadowed updates");
    wait_cnt(5);
    wr_reg(4'd4, 32'd7);
    idle(25);
    wait_cnt(3);
    wr_reg(4'd1, 32'd12);
    idle(30);
    wait_cnt(2);
    wr_reg(4'd1, 32'd10);
    idle(15);

    $display("[TB] dead time");
    wr_reg(4'd4, 32'd8);
    idle(15);
    wait_cnt(4);
    wr_reg(4'd5, 32'd3);
    wait_cnt(9);
    count_high(20, 0, highs);
    check_output("dead_time_highs", 32'(highs), 32'd12);
    check_output("dead_time_dir", 32'(pwm_dir[0]), 32'd1);
    idle(5);
    wait_cnt(6);
    wr_reg(4'd5, 32'd2);
    idle(25);

    $display("[TB] interrupts");
    wr_reg(4'd0, 32'd3);
    idle(15);
    rd_reg(4'd2);
    wr_reg(4'd2, 32'd1);
    idle(3);
    wait_cnt(9);
    wr_reg(4'd2, 32'd1);
    rd_reg(4'd2);
    idle(2);
    wr_reg(4'd0, 32'd1);
    wr_reg(4'd2, 32'd1);
    idle(15);
    rd_reg(4'd2);
    rd_reg(4'd0);

    $display("[TB] zero period and disable");
    wr_reg(4'd0, 32'd0);
    wr_reg(4'd1, 32'd0);
    wr_reg(4'd0, 32'd1);
    idle(10);
    rd_reg(4'd3);
    wr_reg(4'd0, 32'd0);
    wr_reg(4'd1, 32'd10);
    wr_reg(4'd9, 32'd3);
    wr_reg(4'd8, 32'd5);
    wr_reg(4'd0, 32'd1);
    idle(13);
    wr_reg(4'd0, 32'd0);
    idle(3);
    rd_reg(4'd3);
    check_output("disable_count", avs_readdata, 32'd0);
    check_output("disable_pwm_low", 32'(pwm_out), 32'd0);
    check_output("disable_dir_kept", 32'(pwm_dir[2]), 32'd1);
    wr_reg(4'd13, 32'hFFFF_FFFF);
    for (int i = 12; i < 16; i++) rd_reg(4'(i));
    rd_reg(4'd9);

    $display("[TB] random traffic");
    wr_reg(4'd0, 32'd3);
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 99));
      a  = 4'($urandom_range(0, 15));
      if (op < 20) begin
        if (a == 4'd0)      wr_reg(a, ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'd3);
        else if (a == 4'd1) wr_reg(a, 32'($urandom_range(0, 12)));
        else if (a >= 4'd4 && a[0] == 1'b0) wr_reg(a, 32'($urandom_range(0, 14)));
        else                wr_reg(a, $urandom);
      end else if (op < 45) begin
        rd_reg(a);
      end else begin
        idle(1);
      end
    end

    $display("[TB] reset mid-period");
    wr_reg(4'd1, 32'd10);
    wr_reg(4'd11, 32'd3);
    wr_reg(4'd0, 32'd3);
    idle(27);
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    reset_n = 1'b0;
    #1;
    check_output("midreset_pwm_out", 32'(pwm_out), 32'd0);
    check_output("midreset_pwm_dir", 32'(pwm_dir), 32'd0);
    check_output("midreset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    rd_reg(4'd1);
    check_output("midreset_period_read", avs_readdata, 32'd50000);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gen_multi.md
Name: pwm_gen_multi

Overview:
Parametrised multi-channel successor to the single-channel pwm_gen component, with Avalon-MM register access for the HPS. Per channel it drives a PWM output and a direction output to the motor drivers. Period and duty values are shadowed, so updates are glitch-free. A direction change triggers a dead-time blanking interval, and the block can raise an interrupt at each period wrap.

Parameters:
NUM_CH, 4, number of PWM/direction channel pairs (1..6)
CNT_W, 16, width of the period counter, period and duty values (8..31)
ADDR_W, 4, Avalon word-address width; 4+2*NUM_CH must be <= 2**ADDR_W
DEFAULT_PERIOD, 50000, period reset value in clk cycles (1 kHz at 50 MHz)
DEAD_CYCLES, 64, clk cycles pwm_out is forced low after an applied direction change (0 disables blanking)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered, read latency 1
irq  out  1  level interrupt, active high
pwm_out  out  NUM_CH  PWM outputs, bit k = channel k
pwm_dir  out  NUM_CH  direction outputs, bit k = channel k

Behaviour:
- Reset (async, all registers): pwm_out=0, pwm_dir=0, irq=0, avs_readdata=0, CTRL=0, STATUS=0, period shadow=DEFAULT_PERIOD, all DUTY=0, all CFG=0, cnt=0, dead counters=0.
- Register map (word address):
  - 0 CTRL RW: b0 global enable EN, b1 IRQ enable IE.
  - 1 PERIOD RW: bits CNT_W-1:0.
  - 2 STATUS: b0 WRAP flag; write 1 to clear.
  - 3 COUNT RO: current cnt value.
  - 4+2k DUTY_k RW: bits CNT_W-1:0.
  - 5+2k CFG_k RW: b0 DIR, b1 channel enable CHEN.
  - Unmapped addresses read 0; writes to them are ignored. Unused high bits read 0.
- Reads return the shadow values. avs_readdata is valid the cycle after avs_read and holds otherwise.
- Shadow/active registers:
  - Writes go to the shadow registers only.
  - Active period, duty, DIR and CHEN load from the shadows at the period boundary, i.e. the cycle when cnt wraps to 0.
  - While EN=0, the active registers copy the shadows every cycle.
- Counter:
  - EN=0 or active period=0: cnt held at 0.
  - Otherwise cnt increments each cycle and wraps from period-1 to 0. Period=1 keeps cnt=0 permanently and counts as a boundary every cycle.
- Output: pwm_out[k] is registered, 1 cycle after the cnt value it reflects. pwm_out[k] = EN & CHEN_k & (cnt < duty_k) & (dead_k==0).
  - duty=0 gives constant low.
  - duty >= period gives constant high (100%).
- Direction: pwm_dir[k] is registered from the active DIR_k and changes only at a boundary, or immediately while EN=0.
- Dead time:
  - When a boundary load changes the active DIR_k, dead_k loads DEAD_CYCLES in the same cycle, then decrements once per cycle down to 0.
  - pwm_out[k] stays low while dead_k != 0. Blanking may span boundaries.
  - A further DIR flip at a later boundary reloads dead_k.
  - A DIR change applied while EN=0 also loads dead_k.
- IRQ:
  - WRAP sets at every boundary while EN=1.
  - If a set and a write-1-to-clear land in the same cycle, the set wins.
  - irq = WRAP & IE, registered.
- EN 1->0: cnt goes to 0, pwm_out all low on the next cycle. pwm_dir holds its last value. WRAP is untouched.
- EN 0->1: counting starts at cnt=0, using the values already copied into the active registers.
- Reset asserted mid-period: all outputs go low immediately (asynchronous). Operation restarts from the reset values.

Test Plan:
- Basic PWM: PERIOD=10, DUTY_0=3, CFG_0=0b10, CTRL=1 -> pwm_out[0] high for 3 cycles, low for 7, repeating. Other channels stay low. COUNT reads cycle through 0..9.
- Duty limits: DUTY_1=0 -> constant low. DUTY_1=10 and DUTY_1=15 with PERIOD=10 -> constant high. PERIOD=0 -> cnt=0 and all outputs low.
- Glitch-free update: write DUTY_0=7 at cnt=5 -> the current period still shows 3 high cycles; the next period shows 7 high cycles. PERIOD change likewise takes effect only at the wrap.
- Dead time (DEAD_CYCLES=4, PERIOD=10, DUTY=8): flip DIR_0 mid-period -> pwm_dir[0] toggles at the next boundary, and pwm_out[0] stays low for cycles 0..3 of that period, high for 4..7, low for 8..9. With no DIR change, pwm_out[0] is high for cycles 0..7.
- IRQ: CTRL=3, PERIOD=10 -> irq rises 1 cycle after the wrap. Writing STATUS=1 clears it. A clear issued in the same cycle as a wrap leaves WRAP=1. IE=0 -> irq stays low while WRAP still sets.
- Reset/disable: assert reset_n=0 mid-period -> pwm_out=0, pwm_dir=0, PERIOD reads 50000. CTRL=0 during a run -> pwm_out low next cycle, COUNT reads 0, pwm_dir retained.
